// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART boot loader.
package uart_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_WIDTH     = 32;

    typedef enum logic [2:0] {
        HEADER,
        CHECK,
        LOAD,
        DONE,
        ERROR
    } loader_state_t;

endpackage

// File: rtl/uart_loader_word_assembler.sv
// Packs accepted UART bytes, MSB first, into 32-bit words and flags the
// byte that completes each word. Used for both the header and the data words.
module word_assembler
    import uart_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  accept,
    input  logic [7:0]            rx_data,
    output logic [WORD_WIDTH-1:0] word,
    output logic                  word_valid
);

    logic [WORD_WIDTH-1:0] sr_q;
    logic [WORD_WIDTH-1:0] sr_d;
    logic [1:0]            bc_q;
    logic [1:0]            bc_d;

    // Shift in each accepted byte; the byte counter wraps after four bytes.
    always_comb begin
        sr_d = sr_q;
        bc_d = bc_q;
        if (accept) begin
            sr_d = {sr_q[WORD_WIDTH-9:0], rx_data};
            bc_d = bc_q + 2'd1;
        end
    end

    // The completed word is presented in the same cycle as its final byte.
    always_comb begin
        word       = {sr_q[WORD_WIDTH-9:0], rx_data};
        word_valid = accept && (bc_q == 2'(BYTES_PER_WORD - 1));
    end

    // Shift register and byte counter storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
            bc_q <= '0;
        end else begin
            sr_q <= sr_d;
            bc_q <= bc_d;
        end
    end

endmodule

// File: rtl/uart_loader.sv
// Boot loader: reads a big-endian word count followed by that many
// big-endian words from the UART byte stream and writes them to
// instruction memory from address 0, holding the CPU in reset meanwhile.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
)
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [WORD_WIDTH-1:0] wdata,
    output logic [WORD_WIDTH-1:0] word_count,
    output logic                  busy,
    output logic                  cpu_rst,
    output logic                  done,
    output logic                  err
);

    // Number of words the memory holds, widened so 2**ADDR_WIDTH never overflows.
    localparam logic [WORD_WIDTH:0] CAPACITY = {{WORD_WIDTH{1'b0}}, 1'b1} << ADDR_WIDTH;

    loader_state_t         state_q;
    loader_state_t         state_d;
    logic [ADDR_WIDTH:0]   idx_q;
    logic [ADDR_WIDTH:0]   idx_d;
    logic                  we_q;
    logic                  we_d;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [ADDR_WIDTH-1:0] waddr_d;
    logic [WORD_WIDTH-1:0] wdata_q;
    logic [WORD_WIDTH-1:0] wdata_d;
    logic [WORD_WIDTH-1:0] word_count_q;
    logic [WORD_WIDTH-1:0] word_count_d;

    logic                  accept;
    logic [WORD_WIDTH-1:0] word;
    logic                  word_valid;
    logic [ADDR_WIDTH:0]   idx_plus_one;
    logic                  last_word;

    // Bytes are only taken while waiting for the header or for data words.
    always_comb begin
        accept       = rx_valid && ((state_q == HEADER) || (state_q == LOAD));
        idx_plus_one = idx_q + 1'b1;
        last_word    = ({{(WORD_WIDTH-ADDR_WIDTH-1){1'b0}}, idx_plus_one} == word_count_q);
    end

    word_assembler u_word_assembler (
        .clk        (CLK),
        .rst        (RST),
        .accept     (accept),
        .rx_data    (rx_data),
        .word       (word),
        .word_valid (word_valid)
    );

    // Next-state logic: latch the header, validate it, then issue one write per word.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        we_d         = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        word_count_d = word_count_q;
        case (state_q)
            HEADER: begin
                if (word_valid) begin
                    word_count_d = word;
                    state_d      = CHECK;
                end
            end
            CHECK: begin
                if (word_count_q == '0) begin
                    state_d = DONE;
                end else if ({1'b0, word_count_q} > CAPACITY) begin
                    state_d = ERROR;
                end else begin
                    idx_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (word_valid) begin
                    we_d    = 1'b1;
                    wdata_d = word;
                    waddr_d = idx_q[ADDR_WIDTH-1:0];
                    idx_d   = idx_plus_one;
                    if (last_word) begin
                        state_d = DONE;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // State, index and write-port registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= HEADER;
            idx_q        <= '0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            word_count_q <= word_count_d;
        end
    end

    // Status outputs decode directly from the registered state.
    always_comb begin
        we         = we_q;
        waddr      = waddr_q;
        wdata      = wdata_q;
        word_count = word_count_q;
        busy       = (state_q == HEADER) || (state_q == CHECK) || (state_q == LOAD);
        cpu_rst    = busy;
        done       = (state_q == DONE);
        err        = (state_q == ERROR);
    end

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: drives the same byte streams into a default-size
// instance and a 4-word instance, and compares both against a stream model.
module tb_uart_loader;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
        logic [31:0] cyc;
        logic        done;
        logic        busy;
        logic        cpu_rst;
    } wr_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;

    logic [1:0]  we_w;
    logic [1:0]  busy_w;
    logic [1:0]  cpurst_w;
    logic [1:0]  done_w;
    logic [1:0]  err_w;
    logic [13:0] waddr0;
    logic [1:0]  waddr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic [31:0] wc0;
    logic [31:0] wc1;
    logic [15:0] waddr_w [2];
    logic [31:0] wdata_w [2];
    logic [31:0] wc_w    [2];

    assign waddr_w[0] = {2'b00, waddr0};
    assign waddr_w[1] = {14'b0, waddr1};
    assign wdata_w[0] = wdata0;
    assign wdata_w[1] = wdata1;
    assign wc_w[0]    = wc0;
    assign wc_w[1]    = wc1;

    int addr_bits [2] = '{14, 2};

    int chk   = 0;
    int fails = 0;
    int cyc   = 0;

    logic [7:0]  byte_q [$];
    int          strb_q [$];
    wr_t         obs_wr [2][$];
    int          obs_done [2];
    int          obs_err  [2];
    wr_t         exp_wr [2][$];
    int          exp_done [2];
    int          exp_err  [2];
    logic [31:0] exp_wc;

    always #5 CLK = ~CLK;

    uart_loader #(.ADDR_WIDTH(14)) dut_big (
        .CLK        (CLK),
        .RST        (RST),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .we         (we_w[0]),
        .waddr      (waddr0),
        .wdata      (wdata0),
        .word_count (wc0),
        .busy       (busy_w[0]),
        .cpu_rst    (cpurst_w[0]),
        .done       (done_w[0]),
        .err        (err_w[0])
    );

    uart_loader #(.ADDR_WIDTH(2)) dut_small (
        .CLK        (CLK),
        .RST        (RST),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .we         (we_w[1]),
        .waddr      (waddr1),
        .wdata      (wdata1),
        .word_count (wc1),
        .busy       (busy_w[1]),
        .cpu_rst    (cpurst_w[1]),
        .done       (done_w[1]),
        .err        (err_w[1])
    );

    // Monitor on the falling edge: log strobed bytes, writes and first done/err cycles.
    always @(negedge CLK) begin
        wr_t r;
        cyc++;
        if (!RST) begin
            if (rx_valid) begin
                byte_q.push_back(rx_data);
                strb_q.push_back(cyc);
            end
            for (int d = 0; d < 2; d++) begin
                if (we_w[d]) begin
                    r.addr    = waddr_w[d];
                    r.data    = wdata_w[d];
                    r.cyc     = 32'(cyc);
                    r.done    = done_w[d];
                    r.busy    = busy_w[d];
                    r.cpu_rst = cpurst_w[d];
                    obs_wr[d].push_back(r);
                end
                if (done_w[d] && obs_done[d] < 0) obs_done[d] = cyc;
                if (err_w[d] && obs_err[d] < 0) obs_err[d] = cyc;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge CLK);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[31-8*i -: 8]);
            if (max_gap > 0) idle($urandom_range(max_gap, 0));
        end
    endtask

    task automatic clear_logs();
        byte_q.delete();
        strb_q.delete();
        for (int d = 0; d < 2; d++) begin
            obs_wr[d].delete();
            obs_done[d] = -1;
            obs_err[d]  = -1;
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        idle(2);
        clear_logs();
        RST = 1'b0;
    endtask

    // Reference model: interprets the logged byte stream as header + words.
    task automatic model_run();
        longint n;
        longint cap;
        int     hdr;
        int     k;
        longint got;
        logic [31:0] w;
        wr_t    r;
        exp_wc = 32'h0;
        for (int d = 0; d < 2; d++) begin
            exp_wr[d].delete();
            exp_done[d] = -1;
            exp_err[d]  = -1;
        end
        if (byte_q.size() < 4) return;
        exp_wc = {byte_q[0], byte_q[1], byte_q[2], byte_q[3]};
        n      = longint'(exp_wc);
        hdr    = strb_q[3];
        for (int d = 0; d < 2; d++) begin
            cap = longint'(1) << addr_bits[d];
            if (n == 0) begin
                exp_done[d] = hdr + 2;
            end else if (n > cap) begin
                exp_err[d] = hdr + 2;
            end else begin
                k   = 0;
                got = 0;
                w   = 32'h0;
                for (int i = 4; i < byte_q.size() && got < n; i++) begin
                    if (strb_q[i] != hdr + 1) begin
                        w = {w[23:0], byte_q[i]};
                        k++;
                        if (k == 4) begin
                            k         = 0;
                            r.addr    = 16'(got);
                            r.data    = w;
                            r.cyc     = 32'(strb_q[i] + 1);
                            got++;
                            r.done    = (got == n);
                            r.busy    = (got != n);
                            r.cpu_rst = (got != n);
                            exp_wr[d].push_back(r);
                            if (got == n) exp_done[d] = strb_q[i] + 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        send_word(32'd1, 0);
        idle(1);
        send_word(32'h55AA1234, 0);
        idle(3);
        RST = 1'b1;
        idle(1);
        for (int d = 0; d < 2; d++) begin
            chk++; if (busy_w[d] !== 1'b1) begin fails++; $display("[TB] FAIL reset_busy dut%0d: got %b expected 1", d, busy_w[d]); end
            chk++; if (cpurst_w[d] !== 1'b1) begin fails++; $display("[TB] FAIL reset_cpu_rst dut%0d: got %b expected 1", d, cpurst_w[d]); end
            chk++; if (we_w[d] !== 1'b0) begin fails++; $display("[TB] FAIL reset_we dut%0d: got %b expected 0", d, we_w[d]); end
            chk++; if (done_w[d] !== 1'b0) begin fails++; $display("[TB] FAIL reset_done dut%0d: got %b expected 0", d, done_w[d]); end
            chk++; if (err_w[d] !== 1'b0) begin fails++; $display("[TB] FAIL reset_err dut%0d: got %b expected 0", d, err_w[d]); end
            chk++; if (wdata_w[d] !== 32'h0) begin fails++; $display("[TB] FAIL reset_wdata dut%0d: got %h expected 0", d, wdata_w[d]); end
            chk++; if (wc_w[d] !== 32'h0) begin fails++; $display("[TB] FAIL reset_word_count dut%0d: got %h expected 0", d, wc_w[d]); end
            chk++; if (waddr_w[d] !== 16'h0) begin fails++; $display("[TB] FAIL reset_waddr dut%0d: got %h expected 0", d, waddr_w[d]); end
        end
        RST = 1'b0;
    endtask

    task automatic test_basic_load();
        do_reset();
        send_word(32'd2, 0);
        idle(1);
        send_word(32'hDEADBEEF, 1);
        send_word(32'h01234567, 2);
        idle(4);
        model_run();
        for (int d = 0; d < 2; d++) begin
            chk++; if (obs_wr[d].size() !== exp_wr[d].size()) begin fails++; $display("[TB] FAIL basic_nwrites dut%0d: got %0d expected %0d", d, obs_wr[d].size(), exp_wr[d].size()); end
            for (int i = 0; i < obs_wr[d].size() && i < exp_wr[d].size(); i++) begin
                chk++; if (obs_wr[d][i] !== exp_wr[d][i]) begin fails++; $display("[TB] FAIL basic_write%0d dut%0d: got %h expected %h", i, d, obs_wr[d][i], exp_wr[d][i]); end
            end
            chk++; if (obs_done[d] !== exp_done[d]) begin fails++; $display("[TB] FAIL basic_done_cycle dut%0d: got %0d expected %0d", d, obs_done[d], exp_done[d]); end
            chk++; if (obs_err[d] !== exp_err[d]) begin fails++; $display("[TB] FAIL basic_err_cycle dut%0d: got %0d expected %0d", d, obs_err[d], exp_err[d]); end
            chk++; if (wc_w[d] !== exp_wc) begin fails++; $display("[TB] FAIL basic_word_count dut%0d: got %h expected %h", d, wc_w[d], exp_wc); end
        end
    endtask

    task automatic test_zero_count();
        do_reset();
        send_word(32'd0, 0);
        idle(1);
        send_word(32'hCAFEBABE, 0);
        idle(4);
        model_run();
        for (int d = 0; d < 2; d++) begin
            chk++; if (obs_wr[d].size() !== exp_wr[d].size()) begin fails++; $display("[TB] FAIL zero_nwrites dut%0d: got %0d expected %0d", d, obs_wr[d].size(), exp_wr[d].size()); end
            chk++; if (obs_done[d] !== exp_done[d]) begin fails++; $display("[TB] FAIL zero_done_cycle dut%0d: got %0d expected %0d", d, obs_done[d], exp_done[d]); end
            chk++; if (obs_err[d] !== exp_err[d]) begin fails++; $display("[TB] FAIL zero_err_cycle dut%0d: got %0d expected %0d", d, obs_err[d], exp_err[d]); end
            chk++; if (busy_w[d] !== 1'b0) begin fails++; $display("[TB] FAIL zero_busy dut%0d: got %b expected 0", d, busy_w[d]); end
            chk++; if (wc_w[d] !== exp_wc) begin fails++; $display("[TB] FAIL zero_word_count dut%0d: got %h expected %h", d, wc_w[d], exp_wc); end
        end
    endtask

    task automatic test_header_error();
        do_reset();
        send_word(32'd5, 0);
        idle(1);
        for (int i = 0; i < 6; i++) send_word($urandom, 1);
        idle(4);
        model_run();
        for (int d = 0; d < 2; d++) begin
            chk++; if (obs_wr[d].size() !== exp_wr[d].size()) begin fails++; $display("[TB] FAIL error_nwrites dut%0d: got %0d expected %0d", d, obs_wr[d].size(), exp_wr[d].size()); end
            for (int i = 0; i < obs_wr[d].size() && i < exp_wr[d].size(); i++) begin
                chk++; if (obs_wr[d][i] !== exp_wr[d][i]) begin fails++; $display("[TB] FAIL error_write%0d dut%0d: got %h expected %h", i, d, obs_wr[d][i], exp_wr[d][i]); end
            end
            chk++; if (obs_done[d] !== exp_done[d]) begin fails++; $display("[TB] FAIL error_done_cycle dut%0d: got %0d expected %0d", d, obs_done[d], exp_done[d]); end
            chk++; if (obs_err[d] !== exp_err[d]) begin fails++; $display("[TB] FAIL error_err_cycle dut%0d: got %0d expected %0d", d, obs_err[d], exp_err[d]); end
            chk++; if (wc_w[d] !== exp_wc) begin fails++; $display("[TB] FAIL error_word_count dut%0d: got %h expected %h", d, wc_w[d], exp_wc); end
        end
    endtask

    task automatic test_full_capacity();
        do_reset();
        send_word(32'd4, 0);
        idle(1);
        for (int i = 0; i < 5; i++) send_word($urandom, 2);
        idle(4);
        model_run();
        for (int d = 0; d < 2; d++) begin
            chk++; if (obs_wr[d].size() !== exp_wr[d].size()) begin fails++; $display("[TB] FAIL full_nwrites dut%0d: got %0d expected %0d", d, obs_wr[d].size(), exp_wr[d].size()); end
            for (int i = 0; i < obs_wr[d].size() && i < exp_wr[d].size(); i++) begin
                chk++; if (obs_wr[d][i] !== exp_wr[d][i]) begin fails++; $display("[TB] FAIL full_write%0d dut%0d: got %h expected %h", i, d, obs_wr[d][i], exp_wr[d][i]); end
            end
            chk++; if (obs_done[d] !== exp_done[d]) begin fails++; $display("[TB] FAIL full_done_cycle dut%0d: got %0d expected %0d", d, obs_done[d], exp_done[d]); end
            chk++; if (obs_err[d] !== exp_err[d]) begin fails++; $display("[TB] FAIL full_err_cycle dut%0d: got %0d expected %0d", d, obs_err[d], exp_err[d]); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_word(32'd2, 0);
        idle(1);
        send_word($urandom, 0);
        send_word($urandom, 0);
        idle(4);
        model_run();
        for (int d = 0; d < 2; d++) begin
            chk++; if (obs_wr[d].size() !== exp_wr[d].size()) begin fails++; $display("[TB] FAIL b2b_nwrites dut%0d: got %0d expected %0d", d, obs_wr[d].size(), exp_wr[d].size()); end
            for (int i = 0; i < obs_wr[d].size() && i < exp_wr[d].size(); i++) begin
                chk++; if (obs_wr[d][i] !== exp_wr[d][i]) begin fails++; $display("[TB] FAIL b2b_write%0d dut%0d: got %h expected %h", i, d, obs_wr[d][i], exp_wr[d][i]); end
            end
            chk++;
            if (obs_wr[d].size() < 2) begin
                fails++; $display("[TB] FAIL b2b_spacing dut%0d: got %0d writes expected 2", d, obs_wr[d].size());
            end else if (obs_wr[d][1].cyc - obs_wr[d][0].cyc !== 32'd4) begin
                fails++; $display("[TB] FAIL b2b_spacing dut%0d: got %0d cycles expected 4", d, obs_wr[d][1].cyc - obs_wr[d][0].cyc);
            end
            chk++; if (obs_done[d] !== exp_done[d]) begin fails++; $display("[TB] FAIL b2b_done_cycle dut%0d: got %0d expected %0d", d, obs_done[d], exp_done[d]); end
        end
    endtask

    task automatic test_reset_midload();
        do_reset();
        send_word(32'd2, 0);
        idle(1);
        send_word(32'h11223344, 0);
        send_byte(8'h99);
        send_byte(8'h88);
        idle(2);
        do_reset();
        for (int d = 0; d < 2; d++) begin
            chk++; if (busy_w[d] !== 1'b1) begin fails++; $display("[TB] FAIL midrst_busy dut%0d: got %b expected 1", d, busy_w[d]); end
            chk++; if (wdata_w[d] !== 32'h0) begin fails++; $display("[TB] FAIL midrst_wdata dut%0d: got %h expected 0", d, wdata_w[d]); end
            chk++; if (wc_w[d] !== 32'h0) begin fails++; $display("[TB] FAIL midrst_word_count dut%0d: got %h expected 0", d, wc_w[d]); end
        end
        send_word(32'd1, 0);
        idle(1);
        send_word(32'hCAFEF00D, 1);
        idle(4);
        model_run();
        for (int d = 0; d < 2; d++) begin
            chk++; if (obs_wr[d].size() !== exp_wr[d].size()) begin fails++; $display("[TB] FAIL midrst_nwrites dut%0d: got %0d expected %0d", d, obs_wr[d].size(), exp_wr[d].size()); end
            for (int i = 0; i < obs_wr[d].size() && i < exp_wr[d].size(); i++) begin
                chk++; if (obs_wr[d][i] !== exp_wr[d][i]) begin fails++; $display("[TB] FAIL midrst_write%0d dut%0d: got %h expected %h", i, d, obs_wr[d][i], exp_wr[d][i]); end
            end
            chk++; if (obs_done[d] !== exp_done[d]) begin fails++; $display("[TB] FAIL midrst_done_cycle dut%0d: got %0d expected %0d", d, obs_done[d], exp_done[d]); end
        end
    endtask

    task automatic test_random_streams();
        logic [31:0] n;
        int          nwords;
        for (int t = 0; t < 12; t++) begin
            do_reset();
            case ($urandom_range(9, 0))
                0:       n = 32'h00004001;
                1:       n = 32'hFFFFFFFF;
                2:       n = 32'h00010000;
                default: n = 32'($urandom_range(6, 0));
            endcase
            send_word(n, 0);
            if ($urandom_range(3, 0) == 0) send_byte(8'($urandom));
            else idle(1);
            nwords = (n <= 32'd6) ? int'(n) : 3;
            nwords = nwords + $urandom_range(1, 0);
            for (int i = 0; i < nwords; i++) send_word($urandom, $urandom_range(2, 0));
            idle(5);
            model_run();
            for (int d = 0; d < 2; d++) begin
                chk++; if (obs_wr[d].size() !== exp_wr[d].size()) begin fails++; $display("[TB] FAIL rand%0d_nwrites dut%0d: got %0d expected %0d", t, d, obs_wr[d].size(), exp_wr[d].size()); end
                for (int i = 0; i < obs_wr[d].size() && i < exp_wr[d].size(); i++) begin
                    chk++; if (obs_wr[d][i] !== exp_wr[d][i]) begin fails++; $display("[TB] FAIL rand%0d_write%0d dut%0d: got %h expected %h", t, i, d, obs_wr[d][i], exp_wr[d][i]); end
                end
                chk++; if (obs_done[d] !== exp_done[d]) begin fails++; $display("[TB] FAIL rand%0d_done_cycle dut%0d: got %0d expected %0d", t, d, obs_done[d], exp_done[d]); end
                chk++; if (obs_err[d] !== exp_err[d]) begin fails++; $display("[TB] FAIL rand%0d_err_cycle dut%0d: got %0d expected %0d", t, d, obs_err[d], exp_err[d]); end
                chk++; if (wc_w[d] !== exp_wc) begin fails++; $display("[TB] FAIL rand%0d_word_count dut%0d: got %h expected %h", t, d, wc_w[d], exp_wc); end
            end
        end
    endtask

    // Test sequence.
    initial begin
        clear_logs();
        idle(2);
        test_reset();
        test_basic_load();
        test_zero_count();
        test_header_error();
        test_full_capacity();
        test_back_to_back();
        test_reset_midload();
        test_random_streams();
        $display("End of test - %0d assertions evaluated, %0d failures", chk, fails);
        $finish;
    end

endmodule
